// File: rtl/caja_musical_pkg.sv
// Shared types for the music-box song sequencer: FSM states, note duration
// codes and the code-to-ticks conversion.
package caja_musical_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_PLAY,
      ST_GAP,
      ST_PAUSE
   } estado_t;

   localparam logic [1:0] LEN_HALF = 2'b00;
   localparam logic [1:0] LEN_ONE  = 2'b01;
   localparam logic [1:0] LEN_TWO  = 2'b10;
   localparam logic [1:0] LEN_END  = 2'b11;

   // Full note period in clk cycles for a playable duration code.
   function automatic logic [31:0] duracion(input logic [1:0] len,
                                             input logic [31:0] ticks_beat);
      case (len)
         LEN_HALF: return ticks_beat >> 1;
         LEN_ONE:  return ticks_beat;
         LEN_TWO:  return ticks_beat << 1;
         default:  return ticks_beat;
      endcase
   endfunction

endpackage

// File: rtl/detector_flanco.sv
// Registered rising-edge detector: one-cycle pulse the cycle after a
// 0->1 transition of btn is sampled. History clears on reset.
module detector_flanco (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic flanco
);

   logic prev;

   always_ff @(posedge clk) begin
      if (reset) begin
         prev   <= 1'b0;
         flanco <= 1'b0;
      end else begin
         prev   <= btn;
         flanco <= btn & ~prev;
      end
   end

endmodule

// File: rtl/secuenciador_canciones.sv
// Song sequencer: walks the note ROM of the selected song, timing each note
// as play + silent gap. Define AUTOREPEAT_EN to loop a song instead of idling.
module secuenciador_canciones
   import caja_musical_pkg::*;
#(
   parameter int unsigned TICKS_BEAT = 6000000,
   parameter int unsigned GAP_TICKS  = 600000,
   parameter int unsigned NUM_SONGS  = 4,
   parameter int unsigned MAX_NOTES  = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_play,
   input  logic       btn_next,
   input  logic [1:0] note_len,
   output logic [1:0] song_sel,
   output logic [4:0] note_idx,
   output logic       mute,
   output logic       playing,
   output logic       song_done
);

   localparam logic [31:0] BEAT32 = 32'(TICKS_BEAT);
   localparam logic [31:0] GAP32  = 32'(GAP_TICKS);
   localparam logic [1:0]  SEL_MAX = 2'(NUM_SONGS - 1);
   localparam logic [4:0]  IDX_MAX = 5'(MAX_NOTES - 1);

   estado_t     state, state_n, resume_q, resume_n;
   logic [31:0] cnt, cnt_n, dur, dur_n;
   logic [4:0]  idx_n;
   logic [1:0]  sel_n;
   logic        done_n, fin;
   logic        ev_play, ev_next;

   detector_flanco u_det_play (.clk(clk), .reset(reset), .btn(btn_play), .flanco(ev_play));
   detector_flanco u_det_next (.clk(clk), .reset(reset), .btn(btn_next), .flanco(ev_next));

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         resume_q  <= ST_LOAD;
         cnt       <= '0;
         dur       <= BEAT32;
         note_idx  <= '0;
         song_sel  <= '0;
         song_done <= 1'b0;
      end else begin
         state     <= state_n;
         resume_q  <= resume_n;
         cnt       <= cnt_n;
         dur       <= dur_n;
         note_idx  <= idx_n;
         song_sel  <= sel_n;
         song_done <= done_n;
      end
   end

   always_comb begin
      state_n  = state;
      resume_n = resume_q;
      cnt_n    = cnt;
      dur_n    = dur;
      idx_n    = note_idx;
      sel_n    = song_sel;
      done_n   = 1'b0;
      fin      = 1'b0;

      case (state)
         ST_IDLE: if (ev_play) state_n = ST_LOAD;
         ST_LOAD: begin
            if (note_len == LEN_END) begin
               fin = 1'b1;
            end else begin
               dur_n   = duracion(note_len, BEAT32);
               cnt_n   = '0;
               state_n = ST_PLAY;
            end
         end
         ST_PLAY: begin
            if (cnt == dur - GAP32 - 32'd1) begin
               cnt_n   = '0;
               state_n = ST_GAP;
            end else begin
               cnt_n = cnt + 32'd1;
            end
         end
         ST_GAP: begin
            if (cnt == GAP32 - 32'd1) begin
               cnt_n = '0;
               if (note_idx == IDX_MAX) begin
                  fin = 1'b1;
               end else begin
                  idx_n   = note_idx + 5'd1;
                  state_n = ST_LOAD;
               end
            end else begin
               cnt_n = cnt + 32'd1;
            end
         end
         ST_PAUSE: if (ev_play) state_n = resume_q;
         default:  state_n = ST_IDLE;
      endcase

      // The cycle that sees the pause edge still counts, so the resumed note
      // plays exactly its remaining ticks. An end of song in that cycle wins.
      if (fin) begin
         done_n = 1'b1;
         idx_n  = '0;
         cnt_n  = '0;
`ifdef AUTOREPEAT_EN
         state_n = ST_LOAD;
`else
         state_n = ST_IDLE;
`endif
      end else if (ev_play && (state == ST_PLAY || state == ST_GAP)) begin
         resume_n = state_n;
         state_n  = ST_PAUSE;
      end

      if (ev_next) begin
         sel_n  = (song_sel == SEL_MAX) ? 2'd0 : song_sel + 2'd1;
         idx_n  = '0;
         cnt_n  = '0;
         done_n = 1'b0;
         case (state)
            ST_IDLE:  state_n = ST_IDLE;
            ST_PAUSE: begin
               state_n  = ST_PAUSE;
               resume_n = ST_LOAD;
            end
            default:  state_n = ST_LOAD;
         endcase
      end
   end

   assign mute    = (state != ST_PLAY);
   assign playing = (state == ST_LOAD) || (state == ST_PLAY) || (state == ST_GAP);

endmodule

// File: tb/tb_secuenciador_canciones.sv
// Directed bench for secuenciador_canciones with a note-period position model.
// Honours AUTOREPEAT_EN when defined.
module tb_secuenciador_canciones;

   localparam int TB_BEAT = 8;
   localparam int TB_GAP  = 2;
   localparam int TB_NS   = 3;
   localparam int TB_MN   = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       btn_play = 1'b0;
   logic       btn_next = 1'b0;
   logic [1:0] note_len;
   logic [1:0] song_sel;
   logic [4:0] note_idx;
   logic       mute, playing, song_done;

   logic [1:0] rom [TB_NS][TB_MN];

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   secuenciador_canciones #(
      .TICKS_BEAT(TB_BEAT), .GAP_TICKS(TB_GAP), .NUM_SONGS(TB_NS), .MAX_NOTES(TB_MN)
   ) dut (
      .clk(clk), .reset(reset), .btn_play(btn_play), .btn_next(btn_next),
      .note_len(note_len), .song_sel(song_sel), .note_idx(note_idx),
      .mute(mute), .playing(playing), .song_done(song_done)
   );

   always #5 clk = ~clk;

   assign note_len = (song_sel < 2'd3 && note_idx < 5'd4) ? rom[song_sel][note_idx[1:0]] : 2'b11;

`ifdef AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   // Model: mode 0 idle / 1 active / 2 paused; pos 0 = load cycle,
   // 1..D-GAP = sounding, D-GAP+1..D = silent gap.
   int m_mode, m_pos, m_D, m_idx, m_sel, mode0, pos0, code;
   bit m_done, fin, evp, evn, hp1, hp2, hn1, hn2;

   function automatic int dur_of(input int c);
      if (c == 0) return TB_BEAT / 2;
      if (c == 1) return TB_BEAT;
      return 2 * TB_BEAT;
   endfunction

   always @(posedge clk) begin
      evp = hp1 && !hp2;
      evn = hn1 && !hn2;
      hp2 = hp1; hp1 = btn_play;
      hn2 = hn1; hn1 = btn_next;
      if (reset) begin
         m_mode = 0; m_pos = 0; m_D = TB_BEAT; m_idx = 0; m_sel = 0; m_done = 0;
         hp1 = 0; hp2 = 0; hn1 = 0; hn2 = 0;
      end else begin
         m_done = 0; fin = 0; mode0 = m_mode; pos0 = m_pos;
         case (m_mode)
            0: if (evp) begin m_mode = 1; m_pos = 0; end
            1: begin
               if (m_pos == 0) begin
                  code = int'(rom[m_sel][m_idx]);
                  if (code == 3) fin = 1;
                  else begin m_D = dur_of(code); m_pos = 1; end
               end else if (m_pos < m_D) m_pos++;
               else if (m_idx == TB_MN - 1) fin = 1;
               else begin m_idx++; m_pos = 0; end
               if (fin) begin
                  m_done = 1; m_idx = 0; m_pos = 0; m_mode = AR ? 1 : 0;
               end else if (evp && pos0 != 0) m_mode = 2;
            end
            default: if (evp) m_mode = 1;
         endcase
         if (evn) begin
            m_sel = (m_sel + 1) % TB_NS; m_idx = 0; m_done = 0;
            if (mode0 != 0) m_pos = 0;
            m_mode = mode0;
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_mute", int'(mute),
             int'(!(m_mode == 1 && m_pos >= 1 && m_pos <= m_D - TB_GAP)));
         chk("m_playing", int'(playing), int'(m_mode == 1));
         chk("m_done", int'(song_done), int'(m_done));
         chk("m_sel", int'(song_sel), m_sel);
         chk("m_idx", int'(note_idx), m_idx);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; btn_play = 1'b0; btn_next = 1'b0;
      cyc(2);
      reset = 1'b0;
   endtask

   task automatic pulse_play();
      btn_play = 1'b1; cyc(1); btn_play = 1'b0; cyc(2);
   endtask

   task automatic pulse_next();
      btn_next = 1'b1; cyc(1); btn_next = 1'b0; cyc(2);
   endtask

   task automatic fill_rom(input logic [1:0] c);
      for (int s = 0; s < TB_NS; s++)
         for (int n = 0; n < TB_MN; n++) rom[s][n] = c;
   endtask

   initial begin
      fill_rom(2'b01);
      do_reset();
      chk_en = 1'b1;
      chk("rst_mute", int'(mute), 1);
      chk("rst_playing", int'(playing), 0);
      chk("rst_sel", int'(song_sel), 0);
      chk("rst_idx", int'(note_idx), 0);
      chk("rst_done", int'(song_done), 0);

      // Song 01, 00, 11 with play held high throughout
      rom[0][0] = 2'b01; rom[0][1] = 2'b00; rom[0][2] = 2'b11;
      btn_play = 1'b1;
      cyc(2);
      chk("t1_load_play", int'(playing), 1);
      chk("t1_load_mute", int'(mute), 1);
      for (int i = 0; i < 6; i++) begin cyc(1); chk("t1_n0_play", int'(mute), 0); end
      for (int i = 0; i < 2; i++) begin cyc(1); chk("t1_n0_gap", int'(mute), 1); end
      cyc(1); chk("t1_idx1", int'(note_idx), 1);
      for (int i = 0; i < 2; i++) begin cyc(1); chk("t1_n1_play", int'(mute), 0); end
      for (int i = 0; i < 2; i++) begin cyc(1); chk("t1_n1_gap", int'(mute), 1); end
      cyc(1); chk("t1_idx2", int'(note_idx), 2);
      cyc(1);
      chk("t1_done", int'(song_done), 1);
      chk("t1_idx0", int'(note_idx), 0);
      chk("t1_after_play", int'(playing), AR ? 1 : 0);
      cyc(1); chk("t1_done_once", int'(song_done), 0);
      btn_play = 1'b0;

      // Pause at PLAY cycle 3, hold 20 cycles, resume
      fill_rom(2'b01);
      do_reset();
      btn_play = 1'b1; cyc(1); btn_play = 1'b0;
      cyc(3); btn_play = 1'b1;
      cyc(1); chk("t2_cyc3", int'(mute), 0); btn_play = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cyc(1);
         chk("t2_pause_mute", int'(mute), 1);
         chk("t2_pause_idx", int'(note_idx), 0);
      end
      btn_play = 1'b1;
      cyc(1); chk("t2_still_paused", int'(mute), 1); btn_play = 1'b0;
      for (int i = 0; i < 3; i++) begin cyc(1); chk("t2_resume", int'(mute), 0); end
      cyc(1);
      chk("t2_gap_mute", int'(mute), 1);
      chk("t2_gap_playing", int'(playing), 1);

      // Three next edges from IDLE
      do_reset();
      pulse_next(); chk("t3_sel1", int'(song_sel), 1); chk("t3_mute", int'(mute), 1);
      pulse_next(); chk("t3_sel2", int'(song_sel), 2); chk("t3_idx", int'(note_idx), 0);
      pulse_next(); chk("t3_sel0", int'(song_sel), 0); chk("t3_idle", int'(playing), 0);

      // Play and next together during PLAY: next wins
      do_reset();
      pulse_play();
      btn_play = 1'b1; btn_next = 1'b1; cyc(1);
      btn_play = 1'b0; btn_next = 1'b0; cyc(2);
      chk("t4_sel", int'(song_sel), 1);
      chk("t4_load", int'(playing), 1);
      chk("t4_idx", int'(note_idx), 0);
      cyc(1); chk("t4_no_pause", int'(mute), 0);

      // Reset in the gap of note 2
      do_reset();
      pulse_play();
      cyc(24);
      chk("t5_idx2", int'(note_idx), 2);
      chk("t5_gap", int'(mute), 1);
      reset = 1'b1; cyc(1);
      chk("t5_rst_playing", int'(playing), 0);
      chk("t5_rst_idx", int'(note_idx), 0);
      chk("t5_rst_mute", int'(mute), 1);
      reset = 1'b0;

      // Four two-beat notes, no end code: wrap after the last gap
      fill_rom(2'b10);
      do_reset();
      pulse_play();
      cyc(66);
      chk("t6_last_gap_idx", int'(note_idx), 3);
      chk("t6_no_done_yet", int'(song_done), 0);
      cyc(1);
      chk("t6_done", int'(song_done), 1);
      chk("t6_idx0", int'(note_idx), 0);

      // Next during PAUSE, then play restarts from note 0 of the new song
      fill_rom(2'b01);
      do_reset();
      pulse_play();
      pulse_play();
      chk("t7_paused", int'(playing), 0);
      pulse_next();
      chk("t7_sel", int'(song_sel), 1);
      chk("t7_still_paused", int'(playing), 0);
      pulse_play();
      chk("t7_resumed", int'(playing), 1);
      chk("t7_idx", int'(note_idx), 0);
      cyc(3);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
